aes_inv_round_ctrl: RTL and testbench

// - Iterative AES decryption sequencer. Reuses a single inverse-round datapath
//   (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns) one round per clock.
// - Takes one ciphertext block over a valid/ready handshake and requests round keys
//   by index from the key-schedule store. Returns the plaintext over a valid/ready handshake.
// - Sits between the UART/IO block buffer and the key-expansion RAM in the decrypt path.

---
 rtl/aes_inv_round_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// AES inverse cipher sequencer: one inverse round per clock on a shared datapath; AES_DEC_BLKCNT_EN adds blk_cnt.
// Latency NR+1 clocks from accept to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
module aes_inv_round_ctrl #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:127]      in_data,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [0:127]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:127]      out_data,
`ifdef AES_DEC_BLKCNT_EN
    output logic [31:0]       blk_cnt,
`endif
    output logic              busy
);

    localparam logic [KIDX_W-1:0] NR_IDX = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] ONE    = KIDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse affine map, then multiplicative inverse as a^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] p;
        a = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    state_t            state_q, state_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;
    logic [KIDX_W-1:0] key_idx_q, key_idx_d;
    logic [0:127]      st_q, st_d;
    logic [0:127]      out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [0:127]      sub_bytes;
    logic [0:127]      add_key;
    logic [0:127]      mix_out;

    // Byte b is row b%4, column b/4; InvShiftRows rotates row r right by r columns.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam int SRC = 4 * (((b / 4) - (b % 4) + 4) % 4) + (b % 4);
        assign sub_bytes[8*b +: 8] = inv_sbox(st_q[8*SRC +: 8]);
    end

    assign add_key = sub_bytes ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mix_out[32*c +: 32] = inv_mix_col(add_key[32*c +: 32]);
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        st_d       = st_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d    = in_data;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                st_d    = st_q ^ round_key;
                rnd_d   = NR_IDX - ONE;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_d = mix_out;
                if (rnd_q == ONE) state_d = S_FINAL;
                else              rnd_d   = rnd_q - ONE;
            end
            S_FINAL: begin
                st_d       = add_key;
                out_data_d = add_key;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, decoded from the state being entered.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_ROUND: key_idx_d = rnd_d;
            S_FINAL: key_idx_d = '0;
            default: key_idx_d = NR_IDX;
        endcase
    end

`ifdef AES_DEC_BLKCNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_valid_q && out_ready) blk_cnt_d = blk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) blk_cnt_q <= '0;
        else        blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rnd_q       <= '0;
            key_idx_q   <= NR_IDX;
            st_q        <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            key_idx_q   <= key_idx_d;
            st_q        <= st_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_idx   = key_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: byte-array AES-128 inverse-cipher model plus timing sequences.
module tb_aes_inv_round_ctrl;

    localparam int NR = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic [3:0]   key_idx;
    logic [0:127] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         busy;
`ifdef AES_DEC_BLKCNT_EN
    logic [31:0]  blk_cnt;
`endif

    int errors;
    int checks;
    int idx_viol;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [0:127] ks    [0:NR];

    typedef struct {
        logic [0:127] key;
        logic [0:127] ct;
        logic [0:127] pt;
    } vec_t;
    vec_t vecs [6];

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    aes_inv_round_ctrl #(.NR(NR), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_DEC_BLKCNT_EN
        .blk_cnt   (blk_cnt),
`endif
        .busy      (busy)
    );

    assign round_key = (key_idx <= 4'd10) ? ks[key_idx] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (key_idx > 4'd10) idx_viol++;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // Forward S-box from its definition (brute-force field inverse + affine), inverse by table lookup.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v;
            logic [7:0] inv;
            logic [7:0] a;
            v = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(v, 8'(y)) == 8'h01) inv = 8'(y);
            a = inv ^ rotl(inv) ^ rotl(rotl(inv)) ^ rotl(rotl(rotl(inv)))
                ^ rotl(rotl(rotl(rotl(inv)))) ^ 8'h63;
            sbox[x]  = a;
            isbox[a] = v;
        end
    endtask

    task automatic expand_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] model_dec(input logic [0:127] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [0:127] res;
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ ks[NR][8*i +: 8];
        for (int r = NR - 1; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) t[i] = s[4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4)];
            for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ ks[r][8*i +: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
                    s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
                    s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
                    s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // Accept one block, follow it to DONE, check latency, result and key_idx trace; leaves it in DONE.
    task automatic run_block(input logic [0:127] ct, input logic [0:127] exp_pt, input string nm);
        int n;
        int tr[$];
        bit tr_ok;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tr.push_back(int'(key_idx));
        in_valid = 1'b1;
        in_data  = ct;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = 0;
        while (!out_valid && n < 40) begin
            tr.push_back(int'(key_idx));
            tick();
            n++;
        end
        chk({nm, " latency"}, n, NR + 1);
        chk({nm, " data"}, out_data, exp_pt);
        tr_ok = (tr.size() == NR + 2);
        for (int k = 0; k < tr.size() && k < NR + 2; k++)
            if (tr[k] != ((k == 0) ? NR : NR + 1 - k)) tr_ok = 1'b0;
        chk({nm, " key_idx trace"}, tr_ok, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        int acc[$];
        int outs;
        int cyc;
`ifdef AES_DEC_BLKCNT_EN
        logic [31:0] blk0;
`endif
        errors = 0; checks = 0; idx_viol = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        build_sbox();

        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        vecs[1] = '{key: '0, ct: '0, pt: '0};
        for (int v = 2; v < 6; v++) begin
            vecs[v].key = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[v].ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        for (int v = 1; v < 6; v++) begin
            expand_key(vecs[v].key);
            vecs[v].pt = model_dec(vecs[v].ct);
        end

        repeat (3) tick();
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset key_idx", key_idx, NR);
        chk("reset out_data", out_data, 0);
`ifdef AES_DEC_BLKCNT_EN
        chk("reset blk_cnt", blk_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle in_ready", in_ready, 1);

        foreach (vecs[v]) begin
            expand_key(vecs[v].key);
            run_block(vecs[v].ct, vecs[v].pt, $sformatf("vec%0d", v));
            release_out();
            chk($sformatf("vec%0d idle", v), in_ready, 1);
        end
`ifdef AES_DEC_BLKCNT_EN
        chk("blk_cnt after table", blk_cnt, 6);
`endif

        // Back-pressure in DONE, with a competing in_valid that must not be taken.
        expand_key(C1_KEY);
        run_block(C1_CT, C1_PT, "bp");
        in_valid = 1'b1;
        in_data  = C1_CT;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!(out_valid && out_data == C1_PT && !in_ready && busy)) ok = 1'b0;
        end
        chk("bp hold stable", ok, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release in_ready", in_ready, 1);
        chk("bp release out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("accept after release", busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("post-bp data", out_data, C1_PT);
        release_out();

        // Reset in the middle of a block.
        in_valid = 1'b1;
        in_data  = C1_CT;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (key_idx != 4'd5 && n < 40) begin tick(); n++; end
        chk("reach key_idx 5", key_idx, 5);
        rst_n = 1'b0;
        tick();
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst key_idx", key_idx, NR);
        chk("midrst out_data", out_data, 0);
`ifdef AES_DEC_BLKCNT_EN
        chk("midrst blk_cnt", blk_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();
        run_block(C1_CT, C1_PT, "after rst");
        release_out();

        // Streaming four blocks with out_ready tied high.
`ifdef AES_DEC_BLKCNT_EN
        blk0 = blk_cnt;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        outs = 0; cyc = 0; ok = 1'b1;
        while (outs < 4 && cyc < 200) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid && out_ready) begin
                outs++;
                if (out_data != C1_PT) ok = 1'b0;
            end
            tick();
            cyc++;
            if (acc.size() >= 4) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("stream outputs", outs, 4);
        chk("stream data", ok, 1);
        ok = (acc.size() == 4);
        for (int k = 1; k < acc.size(); k++) if (acc[k] - acc[k-1] != NR + 3) ok = 1'b0;
        chk("stream accept spacing", ok, 1);
`ifdef AES_DEC_BLKCNT_EN
        chk("stream blk_cnt", blk_cnt, blk0 + 32'd4);
`endif

        chk("key_idx range", idx_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
